// File: rtl/register_pkg.sv
// Shared constants and helpers for the register read port.
//   RESP_DEPTH : number of response queue entries
//   addr_w()   : address width for a given register count (minimum 1 bit)
package register_pkg;

  localparam int RESP_DEPTH = 2;

  function automatic int addr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/register_resp_queue.sv
// Two-entry response FIFO. Slot 0 is always the head, so head/valid come
// straight from flops; slot 1 shifts down on a pop. Vacated slots are zeroed
// so an empty queue presents all-zero head data.
// Ports:
//   clk, reset       clock, asynchronous active-low reset
//   push, push_data  enqueue one packed response (caller guarantees not full)
//   pop              dequeue head (caller guarantees not empty)
//   head, head_vld   current head entry and its valid flag
//   count            number of occupied entries (0..2)
module register_resp_queue
  import register_pkg::*;
#(
  parameter int  WIDTH  = 4,
  parameter int  ADDR_W = 3,
  localparam int RW     = WIDTH + ADDR_W + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [RW-1:0] push_data,
  input  logic          pop,
  output logic [RW-1:0] head,
  output logic          head_vld,
  output logic [1:0]    count
);

  logic [RW-1:0] slot0_q, slot0_d;
  logic [RW-1:0] slot1_q, slot1_d;
  logic [1:0]    count_q, count_d;
  logic          vld_q, vld_d;

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) slot0_d = push_data;
        else                 slot1_d = push_data;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        slot0_d = slot1_q;
        slot1_d = '0;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // head leaves; the new entry queues behind whatever remains
        if (count_q == 2'd1) begin
          slot0_d = push_data;
        end else begin
          slot0_d = slot1_q;
          slot1_d = push_data;
        end
      end
      default: ;
    endcase
    vld_d = (count_d != 2'd0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= '0;
      vld_q   <= 1'b0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
      vld_q   <= vld_d;
    end
  end

  assign head     = slot0_q;
  assign head_vld = vld_q;
  assign count    = count_q;

  logic unused_depth;
  assign unused_depth = (RESP_DEPTH == 2);

endmodule

// File: rtl/register_read_port.sv
// Register bank with one write port and a valid/ready read-request port
// answered through a 2-entry response queue. Reads see same-cycle writes.
// Ports:
//   clk, reset                       clock, asynchronous active-low reset
//   wr_en, wr_addr, wr_data          write port (addresses >= DEPTH dropped)
//   rd_req_valid/ready, rd_addr      read request handshake
//   rd_resp_valid/ready              response handshake
//   rd_resp_data/addr/err            head response; err flags addr >= DEPTH
module register_read_port
  import register_pkg::*;
#(
  parameter int  WIDTH  = 4,
  parameter int  DEPTH  = 8,
  localparam int ADDR_W = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_resp_valid,
  input  logic              rd_resp_ready,
  output logic [WIDTH-1:0]  rd_resp_data,
  output logic [ADDR_W-1:0] rd_resp_addr,
  output logic              rd_resp_err
);

  typedef struct packed {
    logic [WIDTH-1:0]  data;
    logic [ADDR_W-1:0] addr;
    logic              err;
  } resp_t;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  resp_t      push_resp, head_resp;
  logic       push, pop, head_vld;
  logic [1:0] count;

  // Storage write; out-of-range addresses match no entry and are dropped.
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en && wr_addr == ADDR_W'(i)) mem_d[i] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) mem_q <= '{default: '0};
    else        mem_q <= mem_d;
  end

  // Response snapshot: error check, then forwarding, then storage.
  always_comb begin
    push_resp      = '0;
    push_resp.addr = rd_addr;
    push_resp.err  = (int'(rd_addr) >= DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_addr == ADDR_W'(i)) push_resp.data = mem_q[i];
    end
    if (!push_resp.err && wr_en && wr_addr == rd_addr) push_resp.data = wr_data;
    if (push_resp.err) push_resp.data = '0;
  end

  // Ready depends only on registered occupancy, never on rd_resp_ready.
  assign rd_req_ready = reset & (count < 2'(RESP_DEPTH));
  assign push         = rd_req_valid & rd_req_ready;
  assign pop          = head_vld & rd_resp_ready;

  register_resp_queue #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_resp),
    .pop       (pop),
    .head      (head_resp),
    .head_vld  (head_vld),
    .count     (count)
  );

  assign rd_resp_valid = head_vld;
  assign rd_resp_data  = head_resp.data;
  assign rd_resp_addr  = head_resp.addr;
  assign rd_resp_err   = head_resp.err;

endmodule

// File: tb/tb_register_read_port.sv
module tb_register_read_port;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // DEPTH=8 instance (a_*), DEPTH=6 instance (b_*)
  logic       a_we, a_rv, a_rqr, a_sv, a_rr, a_err;
  logic [2:0] a_wa, a_ra, a_saddr;
  logic [3:0] a_wd, a_sdata;
  logic       b_we, b_rv, b_rqr, b_sv, b_rr, b_err;
  logic [2:0] b_wa, b_ra, b_saddr;
  logic [3:0] b_wd, b_sdata;

  register_read_port #(.WIDTH(4), .DEPTH(8)) dut8 (
    .clk(clk), .reset(reset), .wr_en(a_we), .wr_addr(a_wa), .wr_data(a_wd),
    .rd_req_valid(a_rv), .rd_req_ready(a_rqr), .rd_addr(a_ra),
    .rd_resp_valid(a_sv), .rd_resp_ready(a_rr), .rd_resp_data(a_sdata),
    .rd_resp_addr(a_saddr), .rd_resp_err(a_err));

  register_read_port #(.WIDTH(4), .DEPTH(6)) dut6 (
    .clk(clk), .reset(reset), .wr_en(b_we), .wr_addr(b_wa), .wr_data(b_wd),
    .rd_req_valid(b_rv), .rd_req_ready(b_rqr), .rd_addr(b_ra),
    .rd_resp_valid(b_sv), .rd_resp_ready(b_rr), .rd_resp_data(b_sdata),
    .rd_resp_addr(b_saddr), .rd_resp_err(b_err));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model for the DEPTH=8 instance: array storage + response queue.
  typedef struct {int data; int addr; int err;} mresp_t;
  int     mmem[8];
  mresp_t mq[$];

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < 8; i++) mmem[i] = 0;
  endtask

  task automatic model_chk(input string tag);
    chk({tag, "_valid"}, a_sv, (mq.size() != 0) ? 1 : 0);
    chk({tag, "_ready"}, a_rqr, (mq.size() < 2) ? 1 : 0);
    if (mq.size() != 0) begin
      chk({tag, "_data"}, a_sdata, mq[0].data);
      chk({tag, "_addr"}, a_saddr, mq[0].addr);
      chk({tag, "_err"},  a_err,   mq[0].err);
    end
  endtask

  // One clock of the DEPTH=8 instance, model advanced with the same inputs.
  task automatic step(input logic we, input int wa, input int wd,
                      input logic rv, input int ra, input logic rr);
    mresp_t r;
    bit acc, pp;
    a_we = we; a_wa = 3'(wa); a_wd = 4'(wd);
    a_rv = rv; a_ra = 3'(ra); a_rr = rr;
    acc = rv && (mq.size() < 2);
    pp  = (mq.size() != 0) && rr;
    r.addr = ra;
    r.err  = 0;
    if (ra >= 8)                   begin r.err = 1; r.data = 0; end
    else if (we && wa == ra)       r.data = wd;
    else                           r.data = mmem[ra];
    @(posedge clk);
    if (pp)  void'(mq.pop_front());
    if (acc) mq.push_back(r);
    if (we && wa < 8) mmem[wa] = wd;
    #1;
    model_chk("model");
  endtask

  task automatic bstep(input logic we, input int wa, input int wd,
                       input logic rv, input int ra);
    b_we = we; b_wa = 3'(wa); b_wd = 4'(wd);
    b_rv = rv; b_ra = 3'(ra); b_rr = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic we; int wa; int wd; logic rv; int ra; logic rr;
    logic ev; int ed; int ea; logic ee; logic er;
  } vec_t;
  vec_t tbl[12];

  function automatic vec_t mk(logic we, int wa, int wd, logic rv, int ra, logic rr,
                              logic ev, int ed, int ea, logic ee, logic er);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.rv = rv; v.ra = ra; v.rr = rr;
    v.ev = ev; v.ed = ed; v.ea = ea; v.ee = ee; v.er = er;
    return v;
  endfunction

  initial begin
    // reads of a freshly reset bank, then forwarding and write visibility
    for (int i = 0; i < 8; i++) tbl[i] = mk(0, 0, 0, 1, i, 1, 1, 0, i, 0, 1);
    tbl[8]  = mk(1, 3, 10, 1, 3, 1, 1, 10, 3, 0, 1);
    tbl[9]  = mk(0, 0, 0,  0, 0, 1, 0, 0,  0, 0, 1);
    tbl[10] = mk(0, 0, 0,  1, 3, 1, 1, 10, 3, 0, 1);
    tbl[11] = mk(0, 0, 0,  0, 0, 1, 0, 0,  0, 0, 1);

    a_we = 0; a_wa = 0; a_wd = 0; a_rv = 0; a_ra = 0; a_rr = 0;
    b_we = 0; b_wa = 0; b_wd = 0; b_rv = 0; b_ra = 0; b_rr = 1;
    model_reset();

    // hold reset with a request pending: nothing may be accepted
    a_rv = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", a_rqr, 0);
    chk("rst_valid", a_sv, 0);
    chk("rst_data",  a_sdata, 0);
    chk("rst_addr",  a_saddr, 0);
    chk("rst_err",   a_err, 0);
    chk("rst_b_ready", b_rqr, 0);
    a_rv = 0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", a_rqr, 1);
    chk("post_rst_valid", a_sv, 0);

    // table-driven vectors
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].rv, tbl[i].ra, tbl[i].rr);
      chk($sformatf("tbl%0d_valid", i), a_sv, tbl[i].ev);
      chk($sformatf("tbl%0d_ready", i), a_rqr, tbl[i].er);
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_data", i), a_sdata, tbl[i].ed);
        chk($sformatf("tbl%0d_addr", i), a_saddr, tbl[i].ea);
        chk($sformatf("tbl%0d_err", i),  a_err,   tbl[i].ee);
      end
    end

    // back-pressure: queued values are snapshots, order kept
    step(1, 1, 3, 0, 0, 1);
    step(1, 2, 6, 0, 0, 1);
    step(0, 0, 0, 1, 1, 0);
    chk("bp_first_ready", a_rqr, 1);
    step(0, 0, 0, 1, 2, 0);
    chk("bp_full_ready", a_rqr, 0);
    step(1, 1, 5, 1, 4, 0);
    chk("bp_hold_ready", a_rqr, 0);
    chk("bp_hold_data",  a_sdata, 3);
    chk("bp_hold_addr",  a_saddr, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("bp_pop1_ready", a_rqr, 1);
    chk("bp_pop1_data",  a_sdata, 6);
    chk("bp_pop1_addr",  a_saddr, 2);
    step(0, 0, 0, 0, 0, 1);
    chk("bp_empty_valid", a_sv, 0);
    step(0, 0, 0, 1, 1, 1);
    chk("bp_new_data", a_sdata, 5);
    step(0, 0, 0, 0, 0, 1);

    // count=1 with push and pop every edge
    for (int i = 0; i < 8; i++) step(1, i, i + 1, 0, 0, 1);
    step(0, 0, 0, 1, 0, 1);
    for (int k = 1; k <= 10; k++) begin
      step(0, 0, 0, 1, k % 8, 1);
      chk($sformatf("b2b%0d_data", k), a_sdata, (k % 8) + 1);
      chk($sformatf("b2b%0d_ready", k), a_rqr, 1);
    end
    step(0, 0, 0, 0, 0, 1);

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 15),
           1'($urandom_range(0, 3) != 0), $urandom_range(0, 7),
           1'($urandom_range(0, 9) < 7));
    end
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);

    // reset with two responses queued
    step(1, 2, 9, 0, 0, 1);
    step(1, 3, 7, 0, 0, 1);
    step(0, 0, 0, 1, 2, 0);
    step(0, 0, 0, 1, 3, 0);
    chk("prerst_valid", a_sv, 1);
    chk("prerst_ready", a_rqr, 0);
    a_rv = 0;
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_valid", a_sv, 0);
    chk("midrst_ready", a_rqr, 0);
    chk("midrst_data",  a_sdata, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    step(0, 0, 0, 1, 2, 1);
    chk("postrst_r2", a_sdata, 0);
    step(0, 0, 0, 1, 3, 1);
    chk("postrst_r3", a_sdata, 0);
    step(0, 0, 0, 0, 0, 1);

    // DEPTH=6: out-of-range reads flag err, writes there are dropped
    a_we = 0; a_rv = 0; a_rr = 0;
    for (int i = 0; i < 6; i++) bstep(1, i, i + 1, 0, 0);
    bstep(0, 0, 0, 1, 7);
    chk("d6_r7_valid", b_sv, 1);
    chk("d6_r7_err",   b_err, 1);
    chk("d6_r7_data",  b_sdata, 0);
    chk("d6_r7_addr",  b_saddr, 7);
    bstep(1, 7, 15, 1, 6);
    chk("d6_r6_err",  b_err, 1);
    chk("d6_r6_data", b_sdata, 0);
    bstep(1, 6, 14, 0, 0);
    for (int i = 0; i < 6; i++) begin
      bstep(0, 0, 0, 1, i);
      chk($sformatf("d6_r%0d_data", i), b_sdata, i + 1);
      chk($sformatf("d6_r%0d_err", i),  b_err, 0);
      chk($sformatf("d6_r%0d_addr", i), b_saddr, i);
    end
    bstep(0, 0, 0, 0, 0);
    chk("d6_drain_valid", b_sv, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/register_read_port.md
# register_read_port

Register bank with one write port and a handshaked read-request/response port, giving pipeline consumers a back-pressurable read interface to the processor's storage registers. Read requests are accepted through a valid/ready handshake and answered one cycle later through a 2-entry response queue. A write and a read to the same address in the same cycle are forwarded, so the reader always sees the newest value.

## Interface
- WIDTH, 4, data bits per register
- DEPTH, 8, number of registers (≥2; need not be a power of two)
- ADDR_W, $clog2(DEPTH), address width (derived, not overridden)

- clk  in  1  single clock, rising-edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  WIDTH  write data
- rd_req_valid  in  1  read request present
- rd_req_ready  out  1  block can accept a request this cycle
- rd_addr  in  ADDR_W  read address, sampled on handshake
- rd_resp_valid  out  1  response at queue head
- rd_resp_ready  in  1  consumer takes head response
- rd_resp_data  out  WIDTH  head response data
- rd_resp_addr  out  ADDR_W  address the head response answers
- rd_resp_err  out  1  head response addressed a register ≥ DEPTH

## Operation
- Storage: DEPTH × WIDTH flops, all cleared to 0 by reset.
- Write: on a rising edge with wr_en=1 and wr_addr<DEPTH, entry wr_addr ← wr_data. wr_addr≥DEPTH: write dropped silently.
- Request accepted when rd_req_valid & rd_req_ready at a rising edge.
- Response data at acceptance: if rd_addr≥DEPTH → data 0, err 1; else if wr_en & wr_addr==rd_addr → wr_data (forwarded); else storage[rd_addr]. err 0 otherwise.
- The response {data, addr, err} is pushed into a 2-entry FIFO on the accepting edge.
- rd_req_ready = reset & (count<2); registered count only, no combinational path from rd_resp_ready.
- Pop on rd_resp_valid & rd_resp_ready. rd_resp_valid = (count≠0).
- Push+pop same edge: count unchanged, order preserved (head pops, new entry queued behind the remaining one).
- count=2: no push possible; a pop frees one slot, so ready rises the next cycle.
- Queue head is stable while rd_resp_valid & !rd_resp_ready: a later write to the same register does not alter queued data; queued values are snapshots.

## Timing
- Reset values: rd_req_ready 0 while reset low, 1 from the first cycle after release; rd_resp_valid 0, rd_resp_data 0, rd_resp_addr 0, rd_resp_err 0; count 0; storage all 0.
- Read latency 1: request accepted at edge N → rd_resp_valid high after edge N.
- Write visibility: a write at edge N is visible to a read accepted at edge N (forwarding) and after.
- Throughput: 1 response per cycle sustained while rd_resp_ready=1.
- Reset asserted mid-operation: queue is flushed and storage cleared immediately (asynchronously); in-flight responses are lost, not delivered.
- Outputs are driven directly from flops, except rd_req_ready, which is one gate from count and reset.

## Structure
- Package register_pkg: ADDR_W helper function, resp_t struct {data, addr, err} parameterised by WIDTH/ADDR_W via typedef in the module, and constant RESP_DEPTH=2.
- One sub-module: register_resp_queue (2-entry FIFO of resp_t with push/pop/count, asynchronous active-low reset).
- Storage, forwarding mux and error check stay in the top module.

## Test plan
- Reset then read all 8 addresses with rd_resp_ready=1 → eight responses, data 0, err 0, addr 0..7 in order, one per cycle after the first.
- Write reg 3 ← 4'hA at edge N with a read of reg 3 accepted at edge N → response data 4'hA, err 0 (forwarding).
- Hold rd_resp_ready=0 and issue reads of 1 and 2 → rd_req_ready falls after the second acceptance; write reg 1 ← 4'h5; release ready → responses return the old values, in order 1 then 2, and ready rises one cycle after the first pop.
- DEPTH=6, read addr 7 → data 0, err 1; write addr 7 ← 4'hF, then read addrs 0..5 → all unchanged.
- Count=1 with push and pop on the same edge → count stays 1 and the FIFO order holds over 10 back-to-back reads of regs holding 4'h1..4'h8.
- Pull reset low with 2 responses queued → rd_resp_valid 0 and rd_req_ready 0 immediately; after release, reading previously written regs returns 0.
